reg_file_scoreboard: RTL and testbench

Register file that feeds the decode stage. It provides two combinational read ports and one write port, and adds a per-register busy scoreboard. Single-bit write-enabled falling-edge flops are the storage write side; this block is the read side. It reports stored data and operand readiness to the issue logic, which tracks pending writebacks through reserve/write events.

---
 rtl/reg_file_scoreboard.sv | 108 ++++++++++
 tb/tb_reg_file_scoreboard.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// Register file with two combinational read ports, one falling-edge write port
// and a per-register busy scoreboard that reports operand readiness to issue.
module reg_file_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit CHECK_EN = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_W-1:0]      rd_addr_a,
   output logic [DATA_W-1:0]      rd_data_a,
   output logic                   rd_ready_a,
   input  logic [ADDR_W-1:0]      rd_addr_b,
   output logic [DATA_W-1:0]      rd_data_b,
   output logic                   rd_ready_b,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   rsv_en,
   input  logic [ADDR_W-1:0]      rsv_addr,
   input  logic                   flush,
   output logic [(2**ADDR_W)-1:0] busy_vec,
   output logic                   err_orphan
);

   localparam int NREG = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [NREG-1:0]   busy_q, busy_d;
   logic              wr_ok, rsv_ok;

   // Register 0 is hardwired: writes and reservations aimed at it are dropped.
   assign wr_ok  = wr_en  && (wr_addr  != '0);
   assign rsv_ok = rsv_en && (rsv_addr != '0);

   // NOTE: the storage array is reset like any other flop because the cleared
   // file must be visible on the read ports while reset is held.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_ok) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of process ordering.
         regs_q[wr_addr] <= wr_data;
      end
   end

   // Priority: flush clears everything, a write clears its entry, and a
   // reservation sets its entry last so it wins over both.
   always_comb begin
      // NOTE: start from a full default so no path leaves busy_d unassigned
      // and no latch is inferred.
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else if (wr_ok) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (rsv_ok) begin
         busy_d[rsv_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   generate
      if (CHECK_EN) begin : g_orphan
         logic err_q, err_d;

         // A writeback nobody reserved points to lost tracking in issue logic;
         // a flush legitimately drops reservations, so its writes are exempt.
         always_comb begin
            err_d = err_q;
            if (wr_ok && !busy_q[wr_addr] && !flush) begin
               err_d = 1'b1;
            end
         end

         always_ff @(negedge clk or negedge reset) begin
            if (!reset) begin
               err_q <= 1'b0;
            end else begin
               err_q <= err_d;
            end
         end

         assign err_orphan = err_q;
      end else begin : g_no_orphan
         assign err_orphan = 1'b0;
      end
   endgenerate

   assign rd_data_a  = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
   assign rd_data_b  = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
   assign rd_ready_a = !busy_q[rd_addr_a];
   assign rd_ready_b = !busy_q[rd_addr_b];
   assign busy_vec   = busy_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: vector table for the scoreboard
// rules plus hand-written reset sequences.
module tb_reg_file_scoreboard;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 2**ADDR_W;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
   logic [DATA_W-1:0] rd_data_a, rd_data_b, wr_data;
   logic              rd_ready_a, rd_ready_b, wr_en, rsv_en, flush;
   logic [NREG-1:0]   busy_vec;
   logic              err_orphan;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   reg_file_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CHECK_EN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_ready_a(rd_ready_a),
      .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_ready_b(rd_ready_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
      .busy_vec(busy_vec), .err_orphan(err_orphan)
   );

   typedef struct {
      logic              wr_en;
      logic [ADDR_W-1:0] wr_addr;
      logic [DATA_W-1:0] wr_data;
      logic              rsv_en;
      logic [ADDR_W-1:0] rsv_addr;
      logic              flush;
      logic [ADDR_W-1:0] ra;
      logic [ADDR_W-1:0] rb;
      logic [DATA_W-1:0] exp_da;
      logic              exp_ra;
      logic [DATA_W-1:0] exp_db;
      logic              exp_rb;
      logic [NREG-1:0]   exp_busy;
      logic              exp_err;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
   endtask

   // Drive after the rising edge, let the falling edge update, sample 1 ns later.
   task automatic cycle();
      @(negedge clk);
      #1;
      @(posedge clk);
   endtask

   task automatic sample_after_edge();
      @(negedge clk);
      #1;
   endtask

   task automatic fill(input int idx, input logic we, input int wa, input logic [31:0] wd,
                       input logic re, input int rsa, input logic fl,
                       input int ra, input int rb,
                       input logic [31:0] da, input logic rya,
                       input logic [31:0] db, input logic ryb,
                       input logic [31:0] busy, input logic err);
      vecs[idx].wr_en    = we;
      vecs[idx].wr_addr  = ADDR_W'(wa);
      vecs[idx].wr_data  = wd;
      vecs[idx].rsv_en   = re;
      vecs[idx].rsv_addr = ADDR_W'(rsa);
      vecs[idx].flush    = fl;
      vecs[idx].ra       = ADDR_W'(ra);
      vecs[idx].rb       = ADDR_W'(rb);
      vecs[idx].exp_da   = da;
      vecs[idx].exp_ra   = rya;
      vecs[idx].exp_db   = db;
      vecs[idx].exp_rb   = ryb;
      vecs[idx].exp_busy = busy;
      vecs[idx].exp_err  = err;
   endtask

   initial begin
      //      we wa  wdata         re ra fl  A  B  exp_da        rya exp_db        ryb busy          err
      fill(0,  0, 0, 32'h0,        1, 5, 0,  5, 0, 32'h0,        0,  32'h0,        1,  32'h0000_0020, 0);
      fill(1,  1, 5, 32'hDEADBEEF, 0, 0, 0,  5, 5, 32'hDEADBEEF, 1,  32'hDEADBEEF, 1,  32'h0,        0);
      fill(2,  0, 0, 32'h0,        1, 9, 0,  9, 5, 32'h0,        0,  32'hDEADBEEF, 1,  32'h0000_0200, 0);
      fill(3,  1, 9, 32'h12,       1, 9, 0,  9, 9, 32'h12,       0,  32'h12,       0,  32'h0000_0200, 0);
      fill(4,  1, 9, 32'h34,       0, 0, 0,  9, 0, 32'h34,       1,  32'h0,        1,  32'h0,        0);
      fill(5,  1, 0, 32'hFFFFFFFF, 1, 0, 0,  0, 0, 32'h0,        1,  32'h0,        1,  32'h0,        0);
      fill(6,  0, 0, 32'h0,        1, 1, 0,  1, 0, 32'h0,        0,  32'h0,        1,  32'h0000_0002, 0);
      fill(7,  0, 0, 32'h0,        1, 2, 0,  2, 1, 32'h0,        0,  32'h0,        0,  32'h0000_0006, 0);
      fill(8,  0, 0, 32'h0,        1, 3, 0,  3, 2, 32'h0,        0,  32'h0,        0,  32'h0000_000E, 0);
      fill(9,  1, 6, 32'h66,       1, 4, 1,  6, 4, 32'h66,       1,  32'h0,        0,  32'h0000_0010, 0);
      fill(10, 1, 2, 32'hAB,       0, 0, 0,  2, 1, 32'hAB,       1,  32'h0,        1,  32'h0000_0010, 1);
      fill(11, 0, 0, 32'h0,        1, 4, 0,  2, 4, 32'hAB,       1,  32'h0,        0,  32'h0000_0010, 1);
      fill(12, 1, 4, 32'h44,       0, 0, 0,  4, 2, 32'h44,       1,  32'hAB,       1,  32'h0,        1);

      // Reset held while inputs toggle randomly: nothing may change.
      reset = 1'b0;
      idle_inputs();
      rd_addr_a = '0; rd_addr_b = '0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         wr_en = 1'(($urandom & 1)); wr_addr = ADDR_W'($urandom); wr_data = $urandom;
         rsv_en = 1'(($urandom & 1)); rsv_addr = ADDR_W'($urandom); flush = 1'(($urandom & 1));
         rd_addr_a = ADDR_W'($urandom); rd_addr_b = ADDR_W'($urandom);
         sample_after_edge();
         if (c % 2 == 0) begin
            check("rst_data_a", 64'(rd_data_a), 64'h0);
            check("rst_data_b", 64'(rd_data_b), 64'h0);
            check("rst_ready_a", 64'(rd_ready_a), 64'h1);
            check("rst_ready_b", 64'(rd_ready_b), 64'h1);
            check("rst_busy", 64'(busy_vec), 64'h0);
            check("rst_err", 64'(err_orphan), 64'h0);
         end
      end

      @(posedge clk);
      idle_inputs();
      reset = 1'b1;
      rd_addr_a = 7;
      sample_after_edge();
      check("post_rst_r7", 64'(rd_data_a), 64'h0);
      check("post_rst_r7_ready", 64'(rd_ready_a), 64'h1);

      for (int i = 0; i < 13; i++) begin
         @(posedge clk);
         wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
         rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr; flush = vecs[i].flush;
         rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
         sample_after_edge();
         check($sformatf("v%0d_data_a", i), 64'(rd_data_a), 64'(vecs[i].exp_da));
         check($sformatf("v%0d_ready_a", i), 64'(rd_ready_a), 64'(vecs[i].exp_ra));
         check($sformatf("v%0d_data_b", i), 64'(rd_data_b), 64'(vecs[i].exp_db));
         check($sformatf("v%0d_ready_b", i), 64'(rd_ready_b), 64'(vecs[i].exp_rb));
         check($sformatf("v%0d_busy", i), 64'(busy_vec), 64'(vecs[i].exp_busy));
         check($sformatf("v%0d_err", i), 64'(err_orphan), 64'(vecs[i].exp_err));
      end

      // err_orphan is sticky across idle cycles.
      @(posedge clk);
      idle_inputs();
      cycle();
      check("err_sticky", 64'(err_orphan), 64'h1);

      // Registers 3 and 8 written and then reserved, then reset dropped mid-cycle.
      idle_inputs();
      wr_en = 1'b1; wr_addr = 3; wr_data = 32'h3333; rsv_en = 1'b1; rsv_addr = 3;
      sample_after_edge();
      @(posedge clk);
      wr_addr = 8; wr_data = 32'h8888; rsv_addr = 8;
      rd_addr_a = 3; rd_addr_b = 8;
      sample_after_edge();
      check("pre_async_a", 64'(rd_data_a), 64'h3333);
      check("pre_async_b", 64'(rd_data_b), 64'h8888);
      check("pre_async_busy", 64'(busy_vec), 64'h0000_0108);
      @(posedge clk);
      idle_inputs();
      #2;
      reset = 1'b0;
      #1;
      check("async_a", 64'(rd_data_a), 64'h0);
      check("async_b", 64'(rd_data_b), 64'h0);
      check("async_ready_a", 64'(rd_ready_a), 64'h1);
      check("async_busy", 64'(busy_vec), 64'h0);
      check("async_err", 64'(err_orphan), 64'h0);

      @(posedge clk);
      reset = 1'b1;
      wr_en = 1'b1; wr_addr = 8; wr_data = 32'h55;
      sample_after_edge();
      check("after_rel_orphan", 64'(err_orphan), 64'h1);
      check("after_rel_data", 64'(rd_data_b), 64'h55);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
